fifo_rd_packer: RTL

Read-side consumer for the FIFO block. It runs in the `rd_clk` domain and pops `DATA_WIDTH` words whenever the FIFO is non-empty and the block has room. It packs `PACK_RATIO` consecutive words into one wide word and presents that word on a valid/ready output stream. Partial words leave the block on an idle timeout or on an explicit flush, tagged with a lane-valid mask.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/pack_idle_timer.sv | 36 +++
 rtl/fifo_rd_packer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO read-side blocks
// Contents: clogb2() sizing helper, pack_state_e packer state encoding.
package fifo_pkg;

  // Bits needed to hold values 0..value-1 (ceil(log2(value))); 0 for value <= 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    P_IDLE,
    P_FILL,
    P_PEND
  } pack_state_e;

endpackage

// File: rtl/pack_idle_timer.sv
// rtl/pack_idle_timer.sv - saturating idle counter that flags a partial-word timeout
// Ports: clk, rst (async, active-high), run (count this cycle), clear (zero the count),
//        expired (this idle cycle is the TIMEOUT-th consecutive one; never set when TIMEOUT == 0).
module pack_idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  // Width is forced to at least 1 so TIMEOUT == 0 still elaborates.
  localparam int TW = (clogb2(TIMEOUT + 1) < 1) ? 1 : clogb2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && (count_q != T_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Combinational so the flush lands on the edge that closes the TIMEOUT-th idle cycle.
  assign expired = (TIMEOUT != 0) && run && (count_q >= T_LAST);

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs PACK_RATIO of them into one output word
// Ports: rd_clk, rst (async, active-high); FIFO side fifo_empty/fifo_data in, fifo_rd_en out
//        (combinational pop request); flush in; output stream m_data/m_keep/m_valid out, m_ready in.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             rd_clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int CW = clogb2(PACK_RATIO + 1);
  localparam logic [CW-1:0] LANE_FULL = CW'(PACK_RATIO);

  pack_state_e                                state_q;
  logic [CW-1:0]                              lane_cnt_q;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]      acc_q;

  logic                                       pop;
  logic                                       out_free;
  logic                                       expired;
  logic                                       timer_run;
  logic                                       complete;
  logic                                       load;
  logic [CW-1:0]                              lane_cnt_nxt;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]      acc_nxt;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]      load_data;
  logic [PACK_RATIO-1:0]                      load_keep;

  assign fifo_rd_en = !fifo_empty && (state_q != P_PEND);
  assign pop        = fifo_rd_en && !fifo_empty;
  assign out_free   = !m_valid || m_ready;

  // Accumulator as it will look after this edge, so a word popped together with
  // the completion event is part of the emitted word.
  always_comb begin
    acc_nxt      = acc_q;
    lane_cnt_nxt = lane_cnt_q;
    if (pop) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (lane_cnt_q == CW'(i)) acc_nxt[i] = fifo_data;
      end
      lane_cnt_nxt = lane_cnt_q + 1'b1;
    end
  end

  // Lanes beyond the fill level may still hold an older word; mask them to zero.
  always_comb begin
    load_keep = '0;
    load_data = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      load_keep[i] = (CW'(i) < lane_cnt_nxt);
      load_data[i] = load_keep[i] ? acc_nxt[i] : '0;
    end
  end

  assign complete  = (state_q == P_FILL) &&
                     ((lane_cnt_nxt == LANE_FULL) || flush || expired);
  assign load      = out_free && (complete || (state_q == P_PEND));
  assign timer_run = (state_q == P_FILL) && !pop;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= P_IDLE;
      lane_cnt_q <= '0;
      acc_q      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
    end else begin
      case (state_q)
        P_IDLE: begin
          if (pop) begin
            acc_q      <= acc_nxt;
            lane_cnt_q <= lane_cnt_nxt;
            state_q    <= P_FILL;
          end
        end
        P_FILL: begin
          acc_q      <= acc_nxt;
          lane_cnt_q <= lane_cnt_nxt;
          if (complete) begin
            if (out_free) begin
              lane_cnt_q <= '0;
              state_q    <= P_IDLE;
            end else begin
              state_q    <= P_PEND;
            end
          end
        end
        P_PEND: begin
          if (out_free) begin
            lane_cnt_q <= '0;
            state_q    <= P_IDLE;
          end
        end
        default: begin
          lane_cnt_q <= '0;
          state_q    <= P_IDLE;
        end
      endcase

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_keep  <= load_keep;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (rd_clk),
    .rst     (rst),
    .run     (timer_run),
    .clear   (!timer_run),
    .expired (expired)
  );

endmodule
